// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multichannel PWM block.
package pwm_pkg;

  localparam int unsigned NUM_CH_DEF  = 16;
  localparam int unsigned DUTY_W_DEF  = 8;
  localparam int unsigned PRESC_W_DEF = 8;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_STATIC = 2'd1,
    CH_PWM    = 2'd2
  } ch_mode_e;

  function automatic int unsigned duty_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Keeps the channel-index port at least one bit wide for a single channel.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: staged/active duty pair, compare and registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W = DUTY_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_sel_i,
  input  logic [DUTY_W-1:0] wr_data_i,
  input  logic [DUTY_W-1:0] cnt_nxt_i,
  input  logic              wrap_i,
  input  logic              out_en_i,
  input  logic              pwm_en_i,
  output logic              pwm_o,
  output logic              diff_o
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(duty_max(DUTY_W));

  logic [DUTY_W-1:0] staged_q, staged_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              pwm_q, pwm_d;
  ch_mode_e          mode;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      staged_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      staged_q <= staged_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  // Compare uses next-cycle counter and duty so the output lines up with period_start.
  always_comb begin
    staged_d = wr_sel_i ? wr_data_i : staged_q;
    active_d = (wrap_i || !pwm_en_i) ? staged_d : active_q;
    if (!out_en_i)      mode = CH_OFF;
    else if (!pwm_en_i) mode = CH_STATIC;
    else                mode = CH_PWM;
    pwm_d = 1'b0;
    unique case (mode)
      CH_OFF:    pwm_d = 1'b0;
      CH_STATIC: pwm_d = 1'b1;
      CH_PWM:    pwm_d = (active_d == DUTY_MAX) || (cnt_nxt_i < active_d);
      default:   pwm_d = 1'b0;
    endcase
  end

  assign pwm_o  = pwm_q;
  assign diff_o = (staged_q != active_q);

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared prescaler and period counter driving NUM_CH channels.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter  int unsigned NUM_CH  = NUM_CH_DEF,
  parameter  int unsigned DUTY_W  = DUTY_W_DEF,
  parameter  int unsigned PRESC_W = PRESC_W_DEF,
  localparam int unsigned CH_W    = ch_idx_w(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [DUTY_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0]  out_en,
  input  logic [NUM_CH-1:0]  pwm_en,
  input  logic [PRESC_W-1:0] prescale,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_start,
  output logic               update_pending
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(duty_max(DUTY_W) - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DUTY_W-1:0]  cnt_q, cnt_d;
  logic               tick, wrap;
  logic               period_start_q, pending_q;
  logic [NUM_CH-1:0]  diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= wrap;
      pending_q      <= |diff;
    end
  end

  // ">=" rather than "==" so a lowered prescale never strands the counter.
  always_comb begin
    tick    = (presc_q >= prescale);
    presc_d = tick ? '0 : presc_q + 1'b1;
    wrap    = tick && (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .DUTY_W(DUTY_W)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_sel_i (wr_en && (wr_ch == CH_W'(i))),
      .wr_data_i(wr_data),
      .cnt_nxt_i(cnt_d),
      .wrap_i   (wrap),
      .out_en_i (out_en[i]),
      .pwm_en_i (pwm_en[i]),
      .pwm_o    (pwm_out[i]),
      .diff_o   (diff[i])
    );
  end

  assign period_start   = period_start_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel against a tick-count reference model.
module tb_pwm_multichannel;

  localparam int NCH  = 12;
  localparam int DW   = 8;
  localparam int PW   = 8;
  localparam int CHW  = 4;
  localparam int MAXV = 255;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [NCH-1:0] out_en = '0;
  logic [NCH-1:0] pwm_en = '0;
  logic [PW-1:0]  prescale = '0;
  logic [NCH-1:0] pwm_out;
  logic           period_start;
  logic           update_pending;

  pwm_multichannel #(
    .NUM_CH (NCH),
    .DUTY_W (DW),
    .PRESC_W(PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_ch         (wr_ch),
    .wr_data       (wr_data),
    .out_en        (out_en),
    .pwm_en        (pwm_en),
    .prescale      (prescale),
    .pwm_out       (pwm_out),
    .period_start  (period_start),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] out;
    logic           ps;
    logic           pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: total tick count since reset, duty pairs as plain arrays.
  int m_presc;
  int m_ticks;
  int m_staged[NCH];
  int m_active[NCH];

  logic [NCH-1:0] s_out;
  logic           s_ps, s_pend;
  int             meas_len;
  int             meas_hi[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_ticks = 0;
    for (int i = 0; i < NCH; i++) begin
      m_staged[i] = 0;
      m_active[i] = 0;
    end
  endtask

  // Predicts the DUT state after the coming edge from the inputs now applied.
  task automatic apply();
    exp_t e;
    bit   tick, wrap;
    int   cnt;
    e.pend = 1'b0;
    for (int i = 0; i < NCH; i++) if (m_staged[i] != m_active[i]) e.pend = 1'b1;
    tick = (m_presc >= int'(prescale));
    m_presc = tick ? 0 : m_presc + 1;
    wrap = 1'b0;
    if (tick) begin
      m_ticks++;
      wrap = ((m_ticks % MAXV) == 0);
    end
    if (wr_en && int'(wr_ch) < NCH) m_staged[int'(wr_ch)] = int'(wr_data);
    for (int i = 0; i < NCH; i++) if (wrap || !pwm_en[i]) m_active[i] = m_staged[i];
    cnt = m_ticks % MAXV;
    for (int i = 0; i < NCH; i++)
      e.out[i] = !out_en[i] ? 1'b0 : !pwm_en[i] ? 1'b1 :
                 ((m_active[i] == MAXV) || (cnt < m_active[i]));
    e.ps = wrap;
    q.push_back(e);
  endtask

  function automatic bit will_wrap();
    return (m_presc >= int'(prescale)) && (((m_ticks + 1) % MAXV) == 0);
  endfunction

  task automatic step(input bit do_wr, input int ch, input int data);
    @(negedge clk);
    s_out  = pwm_out;
    s_ps   = period_start;
    s_pend = update_pending;
    wr_en   = do_wr;
    wr_ch   = CHW'(ch);
    wr_data = DW'(data);
    apply();
    @(posedge clk);
    #2;
  endtask

  task automatic measure(input int wr_at = -1, input int wch = 0, input int wdata = 0);
    int n;
    n = 0;
    while (!s_ps && n < 3000) begin
      step(0, 0, 0);
      n++;
    end
    if (!s_ps) begin
      chk("period_start_timeout", 0, 1);
      return;
    end
    meas_len = 0;
    for (int i = 0; i < 5; i++) meas_hi[i] = 0;
    do begin
      meas_len++;
      for (int i = 0; i < 5; i++) if (s_out[i]) meas_hi[i]++;
      if (meas_len == wr_at) step(1, wch, wdata);
      else step(0, 0, 0);
    end while (!s_ps && meas_len < 3000);
    if (!s_ps) chk("period_end_timeout", 0, 1);
  endtask

  // Forces the next measure to wait for a fresh period boundary.
  task automatic skip_to_next();
    s_ps = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (pwm_out !== e.out || period_start !== e.ps || update_pending !== e.pend) begin
          errors++;
          $display("FAIL scoreboard t=%0t pwm_out=%h exp=%h period_start=%b exp=%b pending=%b exp=%b",
                   $time, pwm_out, e.out, period_start, e.ps, update_pending, e.pend);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    s_ps = 1'b0;
    #12;
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_period_start", int'(period_start), 0);
    chk("reset_pending", int'(update_pending), 0);
    @(negedge clk);
    rst = 1'b0;
    apply();
    @(posedge clk);
    #2;

    out_en = '1;
    pwm_en = '1;
    prescale = '0;
    step(1, 0, 128);
    step(1, 1, 0);
    step(1, 2, 255);
    step(1, 3, 1);
    step(1, 4, 50);
    measure();
    chk("period_len_p0", meas_len, 255);
    chk("ch0_high_128", meas_hi[0], 128);
    chk("ch1_duty0", meas_hi[1], 0);
    chk("ch2_dutymax", meas_hi[2], 255);
    chk("ch3_duty1", meas_hi[3], 1);
    skip_to_next();
    measure();
    chk("ch0_high_128_again", meas_hi[0], 128);

    step(1, 0, 64);
    skip_to_next();
    measure();
    chk("ch0_high_64", meas_hi[0], 64);
    measure(100, 0, 200);
    chk("ch0_keep_64_after_midwrite", meas_hi[0], 64);
    measure();
    chk("ch0_high_200", meas_hi[0], 200);
    chk("pending_cleared", int'(s_pend), 0);

    step(1, 0, 10);
    prescale = PW'(3);
    skip_to_next();
    measure();
    skip_to_next();
    measure();
    chk("presc3_period_len", meas_len, 1020);
    chk("presc3_high", meas_hi[0], 40);
    repeat (50) step(0, 0, 0);
    prescale = '0;
    skip_to_next();
    measure();
    chk("presc0_period_len", meas_len, 255);
    chk("presc0_high", meas_hi[0], 10);

    pwm_en[4] = 1'b0;
    measure();
    chk("ch4_static_high", meas_hi[4], 255);
    out_en[4] = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("ch4_disabled", int'(s_out[4]), 0);
    pwm_en[4] = 1'b1;
    out_en[4] = 1'b1;

    for (int n = 0; n < 400 && !will_wrap(); n++) step(0, 0, 0);
    step(1, 3, 77);
    measure();
    chk("wrap_cycle_write_commits", meas_hi[3], 77);

    step(1, 13, 5);
    step(1, 15, 9);
    step(0, 0, 0);
    chk("bad_index_no_pending", int'(s_pend), 0);
    skip_to_next();
    measure();
    chk("bad_index_ch0", meas_hi[0], 10);
    chk("bad_index_ch3", meas_hi[3], 77);

    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) prescale = PW'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) out_en = NCH'($urandom);
      if ($urandom_range(0, 15) == 0) pwm_en = NCH'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 255));
    end

    prescale = '0;
    out_en = '1;
    pwm_en = '1;
    step(1, 0, 30);
    step(1, 1, 90);
    step(1, 2, 180);
    skip_to_next();
    measure();
    repeat (40) step(0, 0, 0);
    rst = 1'b1;
    q.delete();
    model_reset();
    #1;
    chk("async_rst_pwm_out", int'(pwm_out), 0);
    chk("async_rst_period_start", int'(period_start), 0);
    chk("async_rst_pending", int'(update_pending), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply();
    @(posedge clk);
    #2;
    s_ps = 1'b0;
    measure();
    chk("post_rst_len", meas_len, 255);
    chk("post_rst_ch0", meas_hi[0], 0);
    chk("post_rst_ch1", meas_hi[1], 0);
    chk("post_rst_ch2", meas_hi[2], 0);

    repeat (3) step(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
